dmem_responder: RTL and testbench

- Data-memory responder for the MEM stage of the pipelined core. It sits between EXE_MEM and MEM_WB.
- Accepts one load/store request at a time from the core's memory-stage initiator over a valid/ready handshake.
- Holds a word-addressed data array and returns a response after a programmable number of wait states.
- Supplies the read data that MEM_WB forwards to write-back.

---
 rtl/dmem_responder.sv | 151 +++++++++++++++
 tb/tb_dmem_responder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: MEM-stage data memory answering one load/store at a
// time over a valid/ready handshake after a fixed number of wait states.
module dmem_responder #(
    parameter int DW   = 32,
    parameter int DMW  = 4,
    parameter int WAIT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [DMW-1:0]    req_addr,
    input  logic [DW-1:0]     req_wdata,
    input  logic [DW/8-1:0]   req_be,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DW-1:0]     rsp_rdata,
    output logic              rsp_we
);

    localparam int         NB      = DW / 8;
    localparam logic [3:0] LP_WAIT = 4'(WAIT);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic              r_we;
    logic [DMW-1:0]    r_addr;
    logic [DW-1:0]     r_wdata;
    logic [NB-1:0]     r_be;
    logic              r_req_ready;
    logic              r_rsp_valid;
    logic              r_rsp_we;
    logic [DW-1:0]     r_rsp_rdata;
    logic [DW-1:0]     r_mem [2**DMW];

    logic              w_accept;
    logic              w_enter_resp;
    logic              w_cur_we;
    logic [DMW-1:0]    w_cur_addr;
    logic [DW-1:0]     w_cur_wdata;
    logic [NB-1:0]     w_cur_be;
    logic [DW-1:0]     w_merged;

    assign w_accept = req_valid & r_req_ready & (r_state == IDLE);

    // With zero wait states the accept edge is also the RESP-entry edge,
    // so the live request fields are used instead of the registered ones.
    always_comb begin
        w_enter_resp = 1'b0;
        if (r_state == IDLE) begin
            w_enter_resp = w_accept && (WAIT == 0);
        end else if (r_state == BUSY) begin
            w_enter_resp = (r_cnt == 4'd1);
        end
    end

    assign w_cur_we    = (r_state == IDLE) ? req_we    : r_we;
    assign w_cur_addr  = (r_state == IDLE) ? req_addr  : r_addr;
    assign w_cur_wdata = (r_state == IDLE) ? req_wdata : r_wdata;
    assign w_cur_be    = (r_state == IDLE) ? req_be    : r_be;

    always_comb begin
        w_merged = r_mem[w_cur_addr];
        for (int i = 0; i < NB; i++) begin
            if (w_cur_be[i]) begin
                w_merged[8*i +: 8] = w_cur_wdata[8*i +: 8];
            end
        end
    end

    // Array is not reset; a reset on the commit edge suppresses the write.
    always_ff @(posedge clk) begin
        if (rst_n && w_enter_resp && w_cur_we) begin
            r_mem[w_cur_addr] <= w_merged;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_be        <= '0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_we    <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_rsp_valid <= 1'b0;
                    r_rsp_rdata <= '0;
                    r_rsp_we    <= 1'b0;
                    if (w_accept) begin
                        r_we        <= req_we;
                        r_addr      <= req_addr;
                        r_wdata     <= req_wdata;
                        r_be        <= req_be;
                        r_req_ready <= 1'b0;
                        if (w_enter_resp) begin
                            r_state     <= RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_we    <= w_cur_we;
                            r_rsp_rdata <= w_cur_we ? '0 : r_mem[w_cur_addr];
                        end else begin
                            r_state <= BUSY;
                            r_cnt   <= LP_WAIT;
                        end
                    end
                end
                BUSY: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (w_enter_resp) begin
                        r_state     <= RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_we    <= w_cur_we;
                        r_rsp_rdata <= w_cur_we ? '0 : r_mem[w_cur_addr];
                    end
                end
                RESP: begin
                    r_state     <= IDLE;
                    r_req_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                    r_rsp_rdata <= '0;
                    r_rsp_we    <= 1'b0;
                end
                default: begin
                    r_state     <= IDLE;
                    r_req_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                    r_rsp_rdata <= '0;
                    r_rsp_we    <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_we    = r_rsp_we;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: three responders (WAIT=0,1,3) driven by directed
// vectors, corner sequences and random traffic against a word-array model.
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        v   [3];
    logic        we  [3];
    logic [3:0]  adr [3];
    logic [31:0] wd  [3];
    logic [3:0]  be  [3];
    logic        rdy [3];
    logic        rv  [3];
    logic        rwe [3];
    logic [31:0] rd  [3];

    for (genvar k = 0; k < 3; k++) begin : g_dut
        dmem_responder #(
            .DW  (32),
            .DMW (4),
            .WAIT((k == 0) ? 0 : ((k == 1) ? 1 : 3))
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .req_valid(v[k]),
            .req_we   (we[k]),
            .req_addr (adr[k]),
            .req_wdata(wd[k]),
            .req_be   (be[k]),
            .req_ready(rdy[k]),
            .rsp_valid(rv[k]),
            .rsp_rdata(rd[k]),
            .rsp_we   (rwe[k])
        );
    end

    typedef struct {
        int          k;
        logic        we;
        logic [3:0]  addr;
        logic [31:0] wd;
        logic [3:0]  be;
        logic [31:0] exp;
    } vec_t;

    vec_t        tbl [12];
    logic [31:0] mdl [3][16];
    int          n_vec = 0;
    int          n_err = 0;

    function automatic int wt(int k);
        return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
    endfunction

    function automatic logic [31:0] merge(logic [31:0] old,
                                          logic [31:0] d,
                                          logic [3:0]  b);
        logic [31:0] m;
        m = 32'h0;
        for (int i = 0; i < 4; i++)
            if (b[i]) m = m | (32'hFF << (8 * i));
        return (old & ~m) | (d & m);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Called and returns at a negedge.
    task automatic do_req(int k, logic w, logic [3:0] a, logic [31:0] d,
                          logic [3:0] b, logic [31:0] exp);
        int guard;
        int lat;
        guard = 0;
        lat   = wt(k) + 1;
        while (rdy[k] !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("ready_before_req", 32'(rdy[k]), 32'd1);
        v[k] = 1'b1; we[k] = w; adr[k] = a; wd[k] = d; be[k] = b;
        @(posedge clk);
        #1;
        v[k] = 1'b0; wd[k] = $urandom; adr[k] = 4'($urandom);
        for (int j = 1; j <= lat; j++) begin
            @(negedge clk);
            chk("ready_low_busy", 32'(rdy[k]), 32'd0);
            if (j < lat) begin
                chk("rsp_early", 32'(rv[k]), 32'd0);
            end else begin
                chk("rsp_valid", 32'(rv[k]), 32'd1);
                chk("rsp_rdata", rd[k], exp);
                chk("rsp_we", 32'(rwe[k]), 32'(w));
            end
        end
        @(negedge clk);
        chk("rsp_one_cycle", 32'(rv[k]), 32'd0);
        chk("rdata_cleared", rd[k], 32'd0);
        chk("ready_back", 32'(rdy[k]), 32'd1);
        if (w) mdl[k][a] = merge(mdl[k][a], d, b);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        logic        rw;
        logic [3:0]  ra;
        logic [31:0] rdat;
        logic [3:0]  rb;

        tbl[0]  = '{1, 1'b1, 4'd3,  32'hDEADBEEF, 4'hF, 32'h0};
        tbl[1]  = '{1, 1'b0, 4'd3,  32'h0,        4'h0, 32'hDEADBEEF};
        tbl[2]  = '{1, 1'b1, 4'd5,  32'h11223344, 4'hF, 32'h0};
        tbl[3]  = '{1, 1'b1, 4'd5,  32'hAABBCCDD, 4'h5, 32'h0};
        tbl[4]  = '{1, 1'b0, 4'd5,  32'h0,        4'h0, 32'h11BB33DD};
        tbl[5]  = '{1, 1'b1, 4'd5,  32'h55555555, 4'h0, 32'h0};
        tbl[6]  = '{1, 1'b0, 4'd5,  32'h0,        4'h0, 32'h11BB33DD};
        tbl[7]  = '{0, 1'b1, 4'd15, 32'h1,        4'hF, 32'h0};
        tbl[8]  = '{0, 1'b1, 4'd0,  32'h2,        4'hF, 32'h0};
        tbl[9]  = '{0, 1'b0, 4'd15, 32'h0,        4'h0, 32'h1};
        tbl[10] = '{0, 1'b0, 4'd0,  32'h0,        4'h0, 32'h2};
        tbl[11] = '{2, 1'b1, 4'd2,  32'h0BADC0DE, 4'hF, 32'h0};

        for (int k = 0; k < 3; k++) begin
            v[k] = 1'b0; we[k] = 1'b0; adr[k] = '0; wd[k] = '0; be[k] = '0;
            for (int a = 0; a < 16; a++) mdl[k][a] = 32'h0;
        end

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                chk("idle_ready", 32'(rdy[k]), 32'd1);
                chk("idle_valid", 32'(rv[k]), 32'd0);
                chk("idle_rdata", rd[k], 32'd0);
                chk("idle_we", 32'(rwe[k]), 32'd0);
            end
        end

        for (int i = 0; i < 12; i++)
            do_req(tbl[i].k, tbl[i].we, tbl[i].addr, tbl[i].wd,
                   tbl[i].be, tbl[i].exp);

        // WAIT=3 with req_valid held: accept every 5 cycles.
        pulses = 0;
        v[2] = 1'b1; we[2] = 1'b0; adr[2] = 4'd2; wd[2] = '0; be[2] = '0;
        for (int t = 1; t <= 15; t++) begin
            @(negedge clk);
            chk("bp_ready", 32'(rdy[2]), 32'((t % 5) == 0));
            chk("bp_valid", 32'(rv[2]), 32'((t % 5) == 4));
            if (rv[2] === 1'b1) begin
                pulses++;
                chk("bp_rdata", rd[2], mdl[2][2]);
            end
        end
        v[2] = 1'b0;
        chk("bp_pulses", 32'(pulses), 32'd3);

        // Store aborted by reset while BUSY.
        do_req(2, 1'b1, 4'd7, 32'h0, 4'hF, 32'h0);
        v[2] = 1'b1; we[2] = 1'b1; adr[2] = 4'd7;
        wd[2] = 32'hCAFEF00D; be[2] = 4'hF;
        @(posedge clk);
        #1;
        v[2] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_ready", 32'(rdy[2]), 32'd1);
        chk("abort_valid", 32'(rv[2]), 32'd0);
        chk("abort_rdata", rd[2], 32'd0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("abort_no_rsp", 32'(rv[2]), 32'd0);
        end
        do_req(2, 1'b0, 4'd7, 32'h0, 4'h0, 32'h0);

        for (int k = 0; k < 3; k++) begin
            for (int a = 0; a < 16; a++)
                do_req(k, 1'b1, 4'(a), $urandom, 4'hF, 32'h0);
            for (int n = 0; n < 30; n++) begin
                rw   = 1'($urandom_range(0, 1));
                ra   = 4'($urandom_range(0, 15));
                rdat = $urandom;
                rb   = 4'($urandom_range(0, 15));
                do_req(k, rw, ra, rdat, rb, rw ? 32'h0 : mdl[k][ra]);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
